// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its scoreboard.
// The bypass select helper fixes the read-port priority: zero, then wr1, then wr0, then array.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    SEL_ARRAY,
    SEL_WR0,
    SEL_WR1,
    SEL_ZERO
  } byp_sel_t;

  function automatic byp_sel_t bypass_sel(input logic is_zero, input logic wr1_hit,
                                          input logic wr0_hit);
    if (is_zero) return SEL_ZERO;
    if (wr1_hit) return SEL_WR1;
    if (wr0_hit) return SEL_WR0;
    return SEL_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on
// writeback or by the sweep engine, with combinational query ports that see same-cycle updates.
module regfile_scoreboard #(
  parameter int AW  = 5,
  parameter int NRP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr0_en,
  input  logic [AW-1:0]     clr0_addr,
  input  logic              clr1_en,
  input  logic [AW-1:0]     clr1_addr,
  input  logic              sweep_en,
  input  logic [AW-1:0]     sweep_addr,
  input  logic [NRP*AW-1:0] qaddr,
  output logic [NRP-1:0]    qbusy
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0]        busy_q;
  logic [NREG-1:0]        busy_d;
  logic [NRP-1:0][AW-1:0] qa;

  assign qa = qaddr;

  // Issue is applied after the writeback clears so that a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr0_en)  busy_d[clr0_addr]  = 1'b0;
    if (clr1_en)  busy_d[clr1_addr]  = 1'b0;
    if (set_en)   busy_d[set_addr]   = 1'b1;
    if (sweep_en) busy_d[sweep_addr] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    qbusy = '0;
    for (int k = 0; k < NRP; k++) begin
      qbusy[k] = (busy_q[qa[k]] & ~((clr0_en && clr0_addr == qa[k]) ||
                                    (clr1_en && clr1_addr == qa[k])))
               | (set_en && set_addr == qa[k]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, pending-write scoreboard
// and a sequenced clear engine that sweeps one register per cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   raddr_i,
  output logic [NRP*XLEN-1:0] rdata_o,
  output logic [NRP-1:0]      rbusy_o,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                clr_req_i,
  output logic                clr_busy_o,
  output logic                clr_done_o
);

  localparam int NREG = 1 << AW;
  localparam bit Z0   = (ZERO_R0 != 0);

  state_t                   state;
  logic [AW-1:0]            cnt;
  logic                     clr_done;
  logic [XLEN-1:0]          regs [NREG];
  logic [NRP-1:0][AW-1:0]   ra;
  logic [NRP-1:0][XLEN-1:0] rd;
  logic [NRP-1:0]           sb_busy;
  logic                     idle;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     iss_ok;

  assign idle   = (state == ST_IDLE);
  assign wr0_ok = wr0_en_i && idle && !(Z0 && wr0_addr_i == '0);
  assign wr1_ok = wr1_en_i && idle && !(Z0 && wr1_addr_i == '0);
  assign iss_ok = iss_valid_i && idle && !(Z0 && iss_rd_i == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {AW{1'b1}}) begin
            state    <= ST_IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy_o = (state == ST_CLEAR);
  assign clr_done_o = clr_done;

  // NOTE: the array is reset on purpose -- reset must leave every register reading zero,
  // which rules out a plain RAM macro for this file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == ST_CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr_i] <= wr0_data_i;
      if (wr1_ok) regs[wr1_addr_i] <= wr1_data_i;
    end
  end

  assign ra = raddr_i;

  // NOTE: rd gets a default before the loop so no path through this block infers a latch.
  always_comb begin
    rd = '0;
    for (int k = 0; k < NRP; k++) begin
      case (bypass_sel(Z0 && ra[k] == '0, wr1_ok && wr1_addr_i == ra[k],
                       wr0_ok && wr0_addr_i == ra[k]))
        SEL_ZERO: rd[k] = '0;
        SEL_WR1:  rd[k] = wr1_data_i;
        SEL_WR0:  rd[k] = wr0_data_i;
        default:  rd[k] = regs[ra[k]];
      endcase
      if (rst) rd[k] = '0;
    end
  end

  assign rdata_o = rd;

  regfile_scoreboard #(
    .AW (AW),
    .NRP(NRP)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_ok),
    .set_addr  (iss_rd_i),
    .clr0_en   (wr0_ok),
    .clr0_addr (wr0_addr_i),
    .clr1_en   (wr1_ok),
    .clr1_addr (wr1_addr_i),
    .sweep_en  (state == ST_CLEAR),
    .sweep_addr(cnt),
    .qaddr     (raddr_i),
    .qbusy     (sb_busy)
  );

  assign rbusy_o = rst ? '0 : sb_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance plus a 16-entry 4-port instance.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        wr0_en, wr1_en, iss_valid, clr_req, clr_busy, clr_done;
  logic [4:0]  wr0_addr, wr1_addr, iss_rd;
  logic [31:0] wr0_data, wr1_data;

  logic [15:0]  b_raddr;
  logic [127:0] b_rdata;
  logic [3:0]   b_rbusy;
  logic         b_wr0_en, b_wr1_en, b_iss_valid, b_clr_req, b_clr_busy, b_clr_done;
  logic [3:0]   b_wr0_addr, b_wr1_addr, b_iss_rd;
  logic [31:0]  b_wr0_data, b_wr1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .clr_req_i(clr_req), .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  regfile_sb #(.XLEN(32), .AW(4), .NRP(4), .ZERO_R0(1)) dut_b (
    .clk(clk), .rst(rst), .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
    .wr0_en_i(b_wr0_en), .wr0_addr_i(b_wr0_addr), .wr0_data_i(b_wr0_data),
    .wr1_en_i(b_wr1_en), .wr1_addr_i(b_wr1_addr), .wr1_data_i(b_wr1_data),
    .iss_valid_i(b_iss_valid), .iss_rd_i(b_iss_rd),
    .clr_req_i(b_clr_req), .clr_busy_o(b_clr_busy), .clr_done_o(b_clr_done)
  );

  function automatic logic [31:0] rd(input int port);
    return rdata[port*32 +: 32];
  endfunction

  function automatic logic [31:0] brd(input int port);
    return b_rdata[port*32 +: 32];
  endfunction

  task automatic idle_in();
    raddr = '0; wr0_en = 0; wr0_addr = '0; wr0_data = '0; wr1_en = 0; wr1_addr = '0;
    wr1_data = '0; iss_valid = 0; iss_rd = '0; clr_req = 0;
    b_raddr = '0; b_wr0_en = 0; b_wr0_addr = '0; b_wr0_data = '0; b_wr1_en = 0;
    b_wr1_addr = '0; b_wr1_data = '0; b_iss_valid = 0; b_iss_rd = '0; b_clr_req = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h99; iss_valid = 1; iss_rd = 5'd5;
    raddr = {5'd5, 5'd5};
    #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy: got %b expected 00", rbusy); end
    checks++; if ({clr_busy, clr_done} !== 2'b00) begin errors++; $display("FAIL reset_clr: got %b expected 00", {clr_busy, clr_done}); end
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    raddr = {5'd5, 5'd5};
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h expected 0", rd(0)); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_busy_r5: got %b expected 00", rbusy); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_in();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; raddr = {5'd5, 5'd0};
    #1;
    checks++; if (rd(1) !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r5: got %h expected deadbeef", rd(1)); end
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h expected 0", rd(0)); end
    @(negedge clk);
    idle_in();
    raddr = {5'd5, 5'd0};
    #1;
    checks++; if (rd(1) !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r5: got %h expected deadbeef", rd(1)); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_in();
    wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h22; raddr = {5'd0, 5'd7};
    #1;
    checks++; if (rd(0) !== 32'h22) begin errors++; $display("FAIL prio_bypass_r7: got %h expected 22", rd(0)); end
    @(negedge clk);
    idle_in();
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFF; raddr = {5'd0, 5'd7};
    #1;
    checks++; if (rd(0) !== 32'h22) begin errors++; $display("FAIL prio_stored_r7: got %h expected 22", rd(0)); end
    checks++; if (rd(1) !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", rd(1)); end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL r0_stored: got %h expected 0", rd(0)); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle_in();
    iss_valid = 1; iss_rd = 5'd3; raddr = {5'd0, 5'd3};
    #1;
    checks++; if (rbusy !== 2'b01) begin errors++; $display("FAIL sb_issue: got %b expected 01", rbusy); end
    @(negedge clk);
    idle_in();
    wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h33; iss_valid = 1; iss_rd = 5'd3; raddr = {5'd0, 5'd3};
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b expected 1", rbusy[0]); end
    checks++; if (rd(0) !== 32'h33) begin errors++; $display("FAIL sb_bypass_r3: got %h expected 33", rd(0)); end
    @(negedge clk);
    idle_in();
    raddr = {5'd0, 5'd3};
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_stored: got %b expected 1", rbusy[0]); end
    @(negedge clk);
    idle_in();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h34; raddr = {5'd0, 5'd3};
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_clear: got %b expected 0", rbusy[0]); end
    @(negedge clk);
    idle_in();
    iss_valid = 1; iss_rd = 5'd0; raddr = {5'd0, 5'd3};
    #1;
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL sb_cleared_r0iss: got %b expected 00", rbusy); end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL sb_r0_never_busy: got %b expected 0", rbusy[0]); end
  endtask

  task automatic test_clear();
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      idle_in();
      wr0_en = 1; wr0_addr = 5'(r); wr0_data = 32'h01010101 * r;
    end
    @(negedge clk);
    idle_in();
    clr_req = 1;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      idle_in();
      if (j <= 32) begin
        wr0_en = 1; wr0_addr = 5'd31; wr0_data = 32'hAAAA; iss_valid = 1; iss_rd = 5'd31;
        raddr = {5'd2, 5'd31};
      end else begin
        raddr = {5'd0, 5'd4};
        if (j == 33) begin wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'h44; end
      end
      #1;
      if (j <= 32) begin
        checks++; if ({clr_busy, clr_done} !== 2'b10) begin errors++; $display("FAIL sweep_flags c%0d: got %b expected 10", j, {clr_busy, clr_done}); end
        checks++; if (rd(0) !== 32'h1F1F1F1F) begin errors++; $display("FAIL sweep_nobypass c%0d: got %h expected 1f1f1f1f", j, rd(0)); end
        checks++; if (rd(1) !== ((j >= 4) ? 32'h0 : 32'h02020202)) begin errors++; $display("FAIL sweep_r2 c%0d: got %h", j, rd(1)); end
        checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL sweep_noiss c%0d: got %b expected 0", j, rbusy[0]); end
      end else begin
        checks++; if ({clr_busy, clr_done} !== ((j == 33) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL sweep_end c%0d: got %b", j, {clr_busy, clr_done}); end
        checks++; if (rd(0) !== 32'h44) begin errors++; $display("FAIL post_sweep_r4 c%0d: got %h expected 44", j, rd(0)); end
      end
    end
    @(negedge clk);
    idle_in();
    for (int r = 0; r < 32; r++) begin
      raddr = {5'd0, 5'(r)};
      #1;
      checks++; if (rd(0) !== ((r == 4) ? 32'h44 : 32'h0)) begin errors++; $display("FAIL post_sweep_read r%0d: got %h", r, rd(0)); end
      checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL post_sweep_busy r%0d: got %b expected 0", r, rbusy[0]); end
    end
  endtask

  task automatic test_clear_held();
    int seen;
    @(negedge clk);
    idle_in();
    clr_req = 1;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({clr_busy, clr_done} !== ((j == 33) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL held_flags c%0d: got %b", j, {clr_busy, clr_done});
      end
    end
    clr_req = 0;
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      #1;
      if (clr_done) seen++;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL held_second_done: got %0d pulses expected 1", seen); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL held_back_idle: got %b expected 0", clr_busy); end
  endtask

  task automatic test_rst_mid_sweep();
    int bad;
    @(negedge clk);
    idle_in();
    wr1_en = 1; wr1_addr = 5'd20; wr1_data = 32'h2020;
    @(negedge clk);
    idle_in();
    clr_req = 1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      idle_in();
      raddr = {5'd0, 5'd20};
    end
    #1;
    checks++; if (clr_busy !== 1'b1 || rd(0) !== 32'h2020) begin errors++; $display("FAIL pre_rst_state: busy %b r20 %h expected 1 2020", clr_busy, rd(0)); end
    rst = 1'b1;
    #1;
    checks++; if ({clr_busy, clr_done} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00", {clr_busy, clr_done}); end
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL rst_mid_r20: got %h expected 0", rd(0)); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      #1;
      if (clr_done || clr_busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", bad); end
    checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL rst_mid_r20_after: got %h expected 0", rd(0)); end
  endtask

  task automatic test_nrp4();
    int nbusy;
    @(negedge clk);
    idle_in();
    b_wr0_en = 1; b_wr0_addr = 4'd3; b_wr0_data = 32'h30303030;
    b_wr1_en = 1; b_wr1_addr = 4'd7; b_wr1_data = 32'h70707070;
    @(negedge clk);
    idle_in();
    b_wr0_en = 1; b_wr0_addr = 4'd12; b_wr0_data = 32'hC0C0C0C0;
    b_wr1_en = 1; b_wr1_addr = 4'd15; b_wr1_data = 32'hF0F0F0F0;
    b_raddr = {4'd15, 4'd12, 4'd7, 4'd3};
    #1;
    checks++; if (b_rdata !== {32'hF0F0F0F0, 32'hC0C0C0C0, 32'h70707070, 32'h30303030}) begin errors++; $display("FAIL nrp4_bypass: got %h", b_rdata); end
    @(negedge clk);
    idle_in();
    b_raddr = {4'd15, 4'd12, 4'd7, 4'd3};
    #1;
    checks++; if (b_rdata !== {32'hF0F0F0F0, 32'hC0C0C0C0, 32'h70707070, 32'h30303030}) begin errors++; $display("FAIL nrp4_stored: got %h", b_rdata); end
    checks++; if (brd(2) !== 32'hC0C0C0C0) begin errors++; $display("FAIL nrp4_port2: got %h expected c0c0c0c0", brd(2)); end
    @(negedge clk);
    idle_in();
    b_iss_valid = 1; b_iss_rd = 4'd15;
    @(negedge clk);
    idle_in();
    b_iss_valid = 1; b_iss_rd = 4'd8; b_raddr = {4'd3, 4'd0, 4'd8, 4'd15};
    #1;
    checks++; if (b_rbusy !== 4'b0011) begin errors++; $display("FAIL nrp4_busy: got %b expected 0011", b_rbusy); end
    @(negedge clk);
    idle_in();
    b_raddr = {4'd3, 4'd0, 4'd8, 4'd15};
    #1;
    checks++; if (b_rbusy !== 4'b0011) begin errors++; $display("FAIL nrp4_busy_stored: got %b expected 0011", b_rbusy); end
    @(negedge clk);
    idle_in();
    b_clr_req = 1;
    nbusy = 0;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      idle_in();
      b_raddr = {4'd3, 4'd0, 4'd8, 4'd15};
      #1;
      if (b_clr_busy) nbusy++;
      if (j == 17) begin
        checks++; if ({b_clr_busy, b_clr_done} !== 2'b01) begin errors++; $display("FAIL nrp4_done: got %b expected 01", {b_clr_busy, b_clr_done}); end
      end
    end
    checks++; if (nbusy !== 16) begin errors++; $display("FAIL nrp4_sweep_len: got %0d expected 16", nbusy); end
    checks++; if (b_rbusy !== 4'b0000 || b_rdata !== 128'h0) begin errors++; $display("FAIL nrp4_swept: busy %b data %h", b_rbusy, b_rdata); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_scoreboard();
    test_clear();
    test_clear_held();
    test_rst_mid_sweep();
    test_nrp4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with write-through bypass, a per-register pending-write scoreboard and a sequenced clear engine. It is the next-generation register file for the core and sits between decode/issue (read ports, scoreboard set) and writeback (two write ports). It adds to the single-write, two-read file a second writeback port, configurable read-port count, hazard tracking and a bulk clear that does not need a reset.

## Interface
- XLEN, 32: register data width.
- AW, 5: register address width; NREG = 2**AW entries.
- NRP, 2: number of read ports (1..4).
- ZERO_R0, 1: when 1, register 0 reads as 0 and ignores writes and issue.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr_i  in  NRP*AW  read addresses, port k at bits [k*AW +: AW].
- rdata_o  out  NRP*XLEN  read data, combinational.
- rbusy_o  out  NRP  scoreboard busy flag per read port, combinational.
- wr0_en_i, wr0_addr_i (AW), wr0_data_i (XLEN)  in  writeback port 0.
- wr1_en_i, wr1_addr_i (AW), wr1_data_i (XLEN)  in  writeback port 1 (higher priority).
- iss_valid_i  in  1  issue of an instruction that will write iss_rd_i.
- iss_rd_i  in  AW  destination register of issued instruction.
- clr_req_i  in  1  request sweep-clear of all registers and busy bits.
- clr_busy_o  out  1  sweep in progress.
- clr_done_o  out  1  one-cycle pulse at sweep completion.

## Operation
- Reset (async): all registers 0, all busy bits 0, FSM IDLE, counter 0; clr_busy_o=0, clr_done_o=0; rdata_o=0 and rbusy_o=0 while rst high.
- Write: wrX_en_i with addr != 0 (or any addr if ZERO_R0=0) writes at edge. Both ports same address: port 1 data stored.
- Read k: addr 0 (ZERO_R0) -> 0; else wr1 match -> wr1_data_i; else wr0 match -> wr0_data_i; else stored value. Bypass only in IDLE.
- Scoreboard: any effective write to r clears busy[r]; iss_valid_i sets busy[iss_rd_i]. Set and clear of same r in one cycle: set wins. rbusy_o[k] = busy[a] & ~(effective write to a this cycle) | (iss_valid_i & iss_rd_i==a); addr 0 never busy under ZERO_R0.
- FSM states IDLE, CLEAR. IDLE + clr_req_i -> CLEAR, counter=0. CLEAR: each cycle register[counter]=0, busy[counter]=0, counter+1; at counter==NREG-1 -> IDLE, clr_done_o=1 next cycle. clr_req_i in CLEAR ignored.
- During CLEAR: write ports and issue ignored (no effect on array or busy), rdata_o shows stored array contents (no bypass), rbusy_o shows stored busy.
- Counter wraps naturally at NREG; no partial-sweep abort except rst.

## Timing
- Read data and busy: zero-cycle combinational from addresses and write/issue inputs.
- Write visible in stored array the cycle after the edge; same-cycle via bypass.
- Clear latency: clr_req_i sampled at edge E0; clr_busy_o high cycles E0+1..E0+NREG; clr_done_o high cycle E0+NREG+1 only, clr_busy_o low then; writes accepted again from that cycle.
- clr_req_i held high continuously: new sweep starts at the edge that ends clr_done_o cycle (IDLE sampled).
- rst mid-sweep: immediate return to IDLE, all cleared, no clr_done_o pulse.

## Structure
- Package regfile_pkg: default XLEN/AW, FSM state enum (ST_IDLE, ST_CLEAR), helper function for bypass select.
- Sub-module regfile_scoreboard: NREG busy bits, set/clear/sweep-clear inputs, NRP query ports; top holds array, bypass, FSM.

## Test plan
- Reset then write r5=0xDEADBEEF via wr0, read r5 on port 1 same cycle -> 0xDEADBEEF bypassed, next cycle from array.
- wr0 r7=0x11, wr1 r7=0x22 same cycle -> read r7 = 0x22 same cycle and after; write r0=0xFF -> r0 reads 0.
- Issue r3, read r3 -> busy=1; next cycle wr1 r3 with iss_valid_i r3 same cycle -> busy stays 1; later wr0 r3 alone -> busy 0 same cycle.
- Fill r1..r31 nonzero, pulse clr_req_i -> clr_busy_o 32 cycles, clr_done_o one pulse at cycle 33; writes during sweep dropped; all reads 0 after.
- Assert rst at sweep cycle 10 -> clr_busy_o 0 immediately, all registers 0, no clr_done_o.
- NRP=4, AW=4: four simultaneous reads of distinct written registers return correct values; scoreboard covers 16 entries.
